// File: rtl/tile_acc_pkg.sv
// Shared types and width helpers for the tile accumulator.
package tile_acc_pkg;

  // Controller states; a column drain is a run of WRITE words driven by the word counter.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam logic STORE_REDUCE = 1'b0;
  localparam logic STORE_DRAIN  = 1'b1;

  // Width of the cross-column sum: wide enough that adding every column cannot wrap.
  function automatic int unsigned sum_bw(input int unsigned acc_bw, input int unsigned arr_size);
    return acc_bw + $clog2(arr_size);
  endfunction

endpackage

// File: rtl/acc_saturate.sv
// Signed narrowing of a wide value to the output word, with a flag when the value changed.
module acc_saturate #(
  parameter int unsigned IN_BW    = 42,
  parameter int unsigned OUT_BW   = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic signed [IN_BW-1:0]  in_data,
  output logic        [OUT_BW-1:0] out_data,
  output logic                     changed
);

  logic [IN_BW-OUT_BW:0] upper;
  logic                  fits;

  // The value fits when every bit from the output sign bit upward is identical.
  assign upper = in_data[IN_BW-1:OUT_BW-1];
  assign fits  = (&upper) | ~(|upper);

  // Clamp to the signed output range or keep the low bits.
  always_comb begin
    out_data = in_data[OUT_BW-1:0];
    changed  = ~fits;
    if (SATURATE && !fits) begin
      out_data = in_data[IN_BW-1] ? {1'b1, {(OUT_BW-1){1'b0}}} : {1'b0, {(OUT_BW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/tile_accumulator.sv
// Per-column K-tile accumulator with ping-pong shadow and a backpressured output-buffer writer.
module tile_accumulator
  import tile_acc_pkg::*;
#(
  parameter int unsigned ARR_SIZE    = 4,
  parameter int unsigned VERTICAL_BW = 32,
  parameter int unsigned ACC_BW      = 40,
  parameter int unsigned OUT_BW      = 32,
  parameter int unsigned ADDR_BW     = 4,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            acc_clear,
  input  logic                            in_valid,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
  input  logic                            store_req,
  input  logic                            store_mode,
  input  logic [ADDR_BW-1:0]              store_addr,
  output logic                            store_ack,
  output logic                            busy,
  output logic                            ob_wr_en,
  output logic [ADDR_BW-1:0]              ob_wr_addr,
  output logic [OUT_BW-1:0]               ob_wr_data,
  input  logic                            ob_wr_ready,
  output logic                            overflow
);

  localparam int unsigned SUM_BW   = sum_bw(ACC_BW, ARR_SIZE);
  localparam int unsigned IDX_BW   = $clog2(ARR_SIZE);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(ARR_SIZE - 1);

  state_e                     state_q, state_d;
  logic        [IDX_BW-1:0]   idx_q, idx_d;
  logic signed [SUM_BW-1:0]   sum_q, sum_d;
  logic                       mode_q, mode_d;
  logic                       wr_en_q, wr_en_d;
  logic        [ADDR_BW-1:0]  wr_addr_q, wr_addr_d;
  logic        [OUT_BW-1:0]   wr_data_q, wr_data_d;
  logic                       overflow_q, overflow_d;
  logic                       busy_q, busy_d;
  logic signed [ACC_BW-1:0]   acc_q [ARR_SIZE];
  logic signed [ACC_BW-1:0]   acc_d [ARR_SIZE];
  logic signed [ACC_BW-1:0]   shadow_q [ARR_SIZE];
  logic signed [ACC_BW-1:0]   shadow_d [ARR_SIZE];

  logic signed [ACC_BW-1:0]   beat_c [ARR_SIZE];
  logic signed [ACC_BW-1:0]   store_val_c [ARR_SIZE];
  logic                       accept_c;
  logic                       clr_c;
  logic        [IDX_BW-1:0]   idx_nxt_c;
  logic signed [SUM_BW-1:0]   red_sum_c;
  logic                       load_c;
  logic signed [SUM_BW-1:0]   conv_src_c;
  logic        [OUT_BW-1:0]   conv_data_c;
  logic                       conv_changed_c;

  assign accept_c  = store_req && (state_q == ST_IDLE) && !rst;
  assign clr_c     = acc_clear || accept_c;
  assign idx_nxt_c = IDX_BW'(idx_q + 1'b1);
  assign red_sum_c = sum_q + SUM_BW'(shadow_q[idx_q]);

  assign store_ack  = accept_c;
  assign busy       = busy_q;
  assign ob_wr_en   = wr_en_q;
  assign ob_wr_addr = wr_addr_q;
  assign ob_wr_data = wr_data_q;
  assign overflow   = overflow_q;

  // Sign-extend this cycle's beat and form the snapshot value that includes it.
  always_comb begin
    for (int k = 0; k < int'(ARR_SIZE); k++) begin
      beat_c[k]      = in_valid ? ACC_BW'(signed'(in_data[k*VERTICAL_BW +: VERTICAL_BW])) : '0;
      store_val_c[k] = acc_q[k] + beat_c[k];
    end
  end

  // Select the next word to present on the write port and whether one is loaded this cycle.
  always_comb begin
    load_c     = 1'b0;
    conv_src_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && store_mode == STORE_DRAIN) begin
          load_c     = 1'b1;
          conv_src_c = SUM_BW'(store_val_c[0]);
        end
      end
      ST_REDUCE: begin
        if (idx_q == LAST_IDX) begin
          load_c     = 1'b1;
          conv_src_c = red_sum_c;
        end
      end
      ST_WRITE: begin
        if (wr_en_q && ob_wr_ready && mode_q == STORE_DRAIN && idx_q != LAST_IDX) begin
          load_c     = 1'b1;
          conv_src_c = SUM_BW'(shadow_q[idx_nxt_c]);
        end
      end
      default: begin
        load_c = 1'b0;
      end
    endcase
  end

  acc_saturate #(
    .IN_BW    (SUM_BW),
    .OUT_BW   (OUT_BW),
    .SATURATE (SATURATE)
  ) u_sat (
    .in_data  (conv_src_c),
    .out_data (conv_data_c),
    .changed  (conv_changed_c)
  );

  // Next-state for accumulators, shadow, controller and registered write port.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    mode_d     = mode_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overflow_d = acc_clear ? 1'b0 : overflow_q;
    for (int k = 0; k < int'(ARR_SIZE); k++) begin
      acc_d[k]    = (clr_c ? '0 : acc_q[k]) + beat_c[k];
      shadow_d[k] = shadow_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          for (int k = 0; k < int'(ARR_SIZE); k++) begin
            shadow_d[k] = store_val_c[k];
          end
          mode_d    = store_mode;
          idx_d     = '0;
          sum_d     = '0;
          wr_addr_d = store_addr;
          state_d   = (store_mode == STORE_DRAIN) ? ST_WRITE : ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        sum_d = red_sum_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_WRITE;
        end else begin
          idx_d = idx_nxt_c;
        end
      end
      ST_WRITE: begin
        if (wr_en_q && ob_wr_ready) begin
          if (mode_q == STORE_REDUCE || idx_q == LAST_IDX) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
          end else begin
            idx_d     = idx_nxt_c;
            wr_addr_d = ADDR_BW'(wr_addr_q + 1'b1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_c) begin
      wr_en_d    = 1'b1;
      wr_data_d  = conv_data_c;
      overflow_d = overflow_d | conv_changed_c;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sum_q      <= '0;
      mode_q     <= STORE_REDUCE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int k = 0; k < int'(ARR_SIZE); k++) begin
        acc_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      mode_q     <= mode_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      for (int k = 0; k < int'(ARR_SIZE); k++) begin
        acc_q[k]    <= acc_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

endmodule

// File: tb/tb_tile_accumulator.sv
// Bench for tile_accumulator: vector table plus hand sequences for stall, busy and reset cases.
module tb_tile_accumulator;

  localparam int unsigned ARR_SIZE = 4;
  localparam int unsigned VB       = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   acc_clear;
  logic                   in_valid;
  logic [ARR_SIZE*VB-1:0] in_data;
  logic                   store_req;
  logic                   store_mode;
  logic [3:0]             store_addr;
  logic                   store_ack;
  logic                   busy;
  logic                   ob_wr_en;
  logic [3:0]             ob_wr_addr;
  logic [31:0]            ob_wr_data;
  logic                   ob_wr_ready;
  logic                   overflow;

  always #5 clk = ~clk;

  tile_accumulator #(
    .ARR_SIZE(4), .VERTICAL_BW(32), .ACC_BW(40), .OUT_BW(32), .ADDR_BW(4), .SATURATE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .acc_clear(acc_clear), .in_valid(in_valid), .in_data(in_data),
    .store_req(store_req), .store_mode(store_mode), .store_addr(store_addr),
    .store_ack(store_ack), .busy(busy), .ob_wr_en(ob_wr_en), .ob_wr_addr(ob_wr_addr),
    .ob_wr_data(ob_wr_data), .ob_wr_ready(ob_wr_ready), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          nb;
    logic [31:0] col [4];
    logic        mode;
    logic [3:0]  addr;
    int          nw;
    logic [3:0]  ea [4];
    logic [31:0] ed [4];
    logic        eovf;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[6];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc = 0;
  int   first_en = -1;
  int   last_wr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted write is popped and compared against the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && ob_wr_en) begin
      if (first_en < 0) first_en = cyc;
      if (ob_wr_ready) begin
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", ob_wr_addr, ob_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(ob_wr_addr), 64'(e.addr));
          check("wr_data", 64'(ob_wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic clear_acc();
    @(posedge clk); #1 acc_clear = 1'b1;
    @(posedge clk); #1 acc_clear = 1'b0;
  endtask

  task automatic beat(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
    in_valid = 1'b1;
    in_data  = {c3, c2, c1, c0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Raise store_req and hold it until acknowledged; returns the ack cycle (-1 on timeout).
  task automatic do_store(input logic mode, input logic [3:0] addr, input logic bv,
                          input logic [31:0] bval, output int t_ack);
    store_req  = 1'b1;
    store_mode = mode;
    store_addr = addr;
    in_valid   = bv;
    in_data    = {4{bval}};
    t_ack      = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (store_ack) begin
        t_ack    = cyc;
        first_en = -1;
        break;
      end
    end
    if (t_ack < 0) begin
      nvec++;
      nmis++;
      $display("FAIL store_ack_timeout: no ack within 40 cycles");
    end
    @(posedge clk); #1;
    store_req = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
  endtask

  task automatic wait_idle(output int t_idle);
    t_idle = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
    if (t_idle < 0) begin
      nvec++;
      nmis++;
      $display("FAIL idle_timeout: busy still high after 60 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, ti, t2;
    bit seen;

    tbl[0] = '{3, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b0, 4'd5, 1,
               '{4'd5, 4'd0, 4'd0, 4'd0}, '{32'd30, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[1] = '{3, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 4'd14, 4,
               '{4'd14, 4'd15, 4'd0, 4'd1}, '{32'd3, 32'd6, 32'd9, 32'd12}, 1'b0};
    tbl[2] = '{2, '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, 1'b0, 4'd2, 1,
               '{4'd2, 4'd0, 4'd0, 4'd0}, '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, 1'b1};
    tbl[3] = '{2, '{32'hFFFFFFFB, 32'd7, 32'h80000000, 32'hFFFFFFFF}, 1'b1, 4'd8, 4,
               '{4'd8, 4'd9, 4'd10, 4'd11}, '{32'hFFFFFFF6, 32'd14, 32'h80000000, 32'hFFFFFFFE}, 1'b1};
    tbl[4] = '{1, '{32'hFFFFFF9C, 32'd50, 32'd20, 32'd10}, 1'b0, 4'd15, 1,
               '{4'd15, 4'd0, 4'd0, 4'd0}, '{32'hFFFFFFEC, 32'd0, 32'd0, 32'd0}, 1'b0};
    tbl[5] = '{4, '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000}, 1'b0, 4'd0, 1,
               '{4'd0, 4'd0, 4'd0, 4'd0}, '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, 1'b1};

    rst = 1'b1; acc_clear = 1'b0; in_valid = 1'b0; in_data = '0;
    store_req = 1'b0; store_mode = 1'b0; store_addr = '0; ob_wr_ready = 1'b1;
    @(negedge clk);
    check("rst_wr_en", 64'(ob_wr_en), 64'd0);
    check("rst_wr_addr", 64'(ob_wr_addr), 64'd0);
    check("rst_wr_data", 64'(ob_wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_ack", 64'(store_ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven stores: fresh tile, beats, one store, then drain to completion.
    for (int i = 0; i < 6; i++) begin
      clear_acc();
      @(negedge clk);
      check("ovf_after_clear", 64'(overflow), 64'd0);
      @(posedge clk); #1;
      for (int b = 0; b < tbl[i].nb; b++) beat(tbl[i].col[0], tbl[i].col[1], tbl[i].col[2], tbl[i].col[3]);
      for (int w = 0; w < tbl[i].nw; w++) push_wr(tbl[i].ea[w], tbl[i].ed[w]);
      do_store(tbl[i].mode, tbl[i].addr, 1'b0, 32'd0, t);
      wait_idle(ti);
      check("first_write_latency", 64'(first_en - t), (tbl[i].mode == 1'b1) ? 64'd1 : 64'd5);
      check("busy_fall", 64'(ti), 64'(last_wr + 1));
      check("overflow", 64'(overflow), 64'(tbl[i].eovf));
      check("all_words_written", 64'(exp_q.size()), 64'd0);
    end

    // Backpressure on word 1 of a drain: port must hold steady for 3 stalled cycles.
    clear_acc();
    for (int b = 0; b < 3; b++) beat(32'd1, 32'd2, 32'd3, 32'd4);
    push_wr(4'd3, 32'd3); push_wr(4'd4, 32'd6); push_wr(4'd5, 32'd9); push_wr(4'd6, 32'd12);
    ob_wr_ready = 1'b1;
    do_store(1'b1, 4'd3, 1'b0, 32'd0, t);
    @(posedge clk); #1 ob_wr_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_en", 64'(ob_wr_en), 64'd1);
      check("stall_addr", 64'(ob_wr_addr), 64'd4);
      check("stall_data", 64'(ob_wr_data), 64'd6);
    end
    @(posedge clk); #1 ob_wr_ready = 1'b1;
    wait_idle(ti);
    check("stall_all_written", 64'(exp_q.size()), 64'd0);

    // Beat in the accept cycle is part of the snapshot; a beat during the drain is not.
    clear_acc();
    push_wr(4'd0, 32'd1); push_wr(4'd1, 32'd1); push_wr(4'd2, 32'd1); push_wr(4'd3, 32'd1);
    do_store(1'b1, 4'd0, 1'b1, 32'd1, t);
    beat(32'd2, 32'd2, 32'd2, 32'd2);
    wait_idle(ti);
    check("same_cycle_beat_words", 64'(exp_q.size()), 64'd0);

    // Second request while busy is held off; then reset lands in the middle of a write.
    clear_acc();
    beat(32'd1, 32'd2, 32'd3, 32'd4);
    ob_wr_ready = 1'b0;
    push_wr(4'd10, 32'd1); push_wr(4'd11, 32'd2); push_wr(4'd12, 32'd3); push_wr(4'd13, 32'd4);
    do_store(1'b1, 4'd10, 1'b0, 32'd0, t);
    push_wr(4'd7, 32'd0);
    store_req = 1'b1; store_mode = 1'b0; store_addr = 4'd7;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("no_ack_while_busy", 64'(store_ack), 64'd0);
    end
    @(posedge clk); #1 ob_wr_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (store_ack) begin
        seen = 1'b1;
        t2 = cyc;
        check("busy_low_at_accept", 64'(busy), 64'd0);
        break;
      end
    end
    check("second_store_acked", 64'(seen), 64'd1);
    @(posedge clk); #1;
    store_req = 1'b0;
    ob_wr_ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ob_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("reduce_reached_write", 64'(seen), 64'd1);
    check("drain_words_before_rst", 64'(exp_q.size()), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wr_en", 64'(ob_wr_en), 64'd0);
    check("async_rst_wr_addr", 64'(ob_wr_addr), 64'd0);
    check("async_rst_wr_data", 64'(ob_wr_data), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    ob_wr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'd0);
    check("no_write_after_rst", 64'(ob_wr_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
